// File: rtl/jtag_chain_arbiter_pkg.sv
// Shared types for the JTAG/AS pin-set arbiter: FSM states, pin bundle and safe park values.
// Pure declarations; no timing or flow-control behaviour of its own.
package jtag_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PARK,
        OWN
    } arb_state_t;

    typedef struct packed {
        logic tck;
        logic tdi;
        logic tms;
        logic nce;
        logic ncs;
        logic oe;
    } pins_t;

    localparam pins_t PINS_PARK = '{tck: 1'b0, tdi: 1'b0, tms: 1'b1, nce: 1'b1, ncs: 1'b1, oe: 1'b0};

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/jtag_arb_watchdog.sv
// Owner-stall detector: counts sampled edges with no TCK change while the other client waits.
// expire is combinational from the registered count; it is asserted on the TIMEOUT_CYCLES-th idle edge.
module jtag_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic waiting,
    input  logic tck,
    output logic expire
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic            tck_prev;
    logic            toggled;
    logic [TO_W-1:0] idle_cnt;

    assign toggled = (tck != tck_prev);

    // tck_prev follows the selected TCK even outside ownership so the first owned cycle compares cleanly
    always_ff @(posedge clk) begin
        if (rst) begin
            tck_prev <= 1'b0;
            idle_cnt <= '0;
        end else begin
            tck_prev <= tck;
            if (!active || !waiting || toggled) begin
                idle_cnt <= '0;
            end else if (idle_cnt != '1) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    assign expire = (TIMEOUT_CYCLES != 0) && active && waiting && !toggled && (idle_cnt == LIMIT);

endmodule

// File: rtl/jtag_chain_arbiter.sv
// Two-master JTAG/AS pin arbiter: grant PARK_CYCLES+1 edges after request from idle, pins registered (1 edge).
// No backpressure; a client holds req for its session and is revoked by watchdog if it stalls.
module jtag_chain_arbiter
    import jtag_pkg::*;
#(
    parameter int PARK_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 16
) (
    input  logic       CLK,
    input  logic       RST_SYNC,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic [1:0] preempt_o,
    input  logic [1:0] c_tck_i,
    input  logic [1:0] c_tdi_i,
    input  logic [1:0] c_tms_i,
    input  logic [1:0] c_nce_i,
    input  logic [1:0] c_ncs_i,
    input  logic [1:0] c_oe_i,
    output logic [1:0] c_tdo_o,
    output logic [1:0] c_asdo_o,
    output logic       B_TCK,
    output logic       B_TDI,
    output logic       B_TMS,
    output logic       B_NCE,
    output logic       B_NCS,
    output logic       B_OE,
    input  logic       B_TDO,
    input  logic       B_ASDO
);

    localparam int               PC_W      = $clog2(PARK_CYCLES + 1);
    localparam logic [PC_W-1:0] PARK_LAST = PC_W'(PARK_CYCLES - 1);

    arb_state_t      state;
    logic            own;
    logic            target;
    logic            rr;
    logic [PC_W-1:0] park_cnt;
    logic [1:0]      lockout;
    logic [1:0]      eligible;
    pins_t           pins;
    pins_t           own_pins;
    logic            wd_tck;
    logic            wd_expire;

    // A preempted client stays locked out until it has dropped req for at least one edge
    assign eligible = req_i & ~lockout;

    assign own_pins = '{tck: c_tck_i[own], tdi: c_tdi_i[own], tms: c_tms_i[own],
                        nce: c_nce_i[own], ncs: c_ncs_i[own], oe: c_oe_i[own]};

    assign wd_tck = (state == OWN) ? c_tck_i[own] : c_tck_i[target];

    jtag_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_watchdog (
        .clk     (CLK),
        .rst     (RST_SYNC),
        .active  (state == OWN),
        .waiting (eligible[~own]),
        .tck     (wd_tck),
        .expire  (wd_expire)
    );

    always_ff @(posedge CLK) begin
        if (RST_SYNC) begin
            state     <= IDLE;
            own       <= 1'b0;
            target    <= 1'b0;
            rr        <= 1'b0;
            park_cnt  <= '0;
            lockout   <= '0;
            gnt_o     <= '0;
            preempt_o <= '0;
            pins      <= PINS_PARK;
        end else begin
            preempt_o <= '0;
            pins      <= PINS_PARK;
            lockout   <= lockout & req_i;
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        state    <= PARK;
                        park_cnt <= '0;
                        target   <= (eligible == 2'b11) ? rr : eligible[1];
                    end
                end
                PARK: begin
                    if (park_cnt == PARK_LAST) begin
                        park_cnt <= '0;
                        if (eligible[target]) begin
                            state <= OWN;
                            own   <= target;
                            gnt_o <= onehot2(target);
                        end else if (eligible[~target]) begin
                            target <= ~target;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        park_cnt <= park_cnt + 1'b1;
                    end
                end
                OWN: begin
                    park_cnt <= '0;
                    // Release takes priority over a coincident watchdog expiry
                    if (!req_i[own]) begin
                        gnt_o  <= '0;
                        rr     <= ~own;
                        target <= eligible[~own] ? ~own : own;
                        state  <= PARK;
                    end else if (wd_expire) begin
                        gnt_o        <= '0;
                        preempt_o    <= onehot2(own);
                        lockout[own] <= 1'b1;
                        target       <= ~own;
                        state        <= PARK;
                    end else begin
                        pins <= own_pins;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign c_tdo_o  = gnt_o & {2{B_TDO}};
    assign c_asdo_o = gnt_o & {2{B_ASDO}};

    assign B_TCK = pins.tck;
    assign B_TDI = pins.tdi;
    assign B_TMS = pins.tms;
    assign B_NCE = pins.nce;
    assign B_NCS = pins.ncs;
    assign B_OE  = pins.oe;

endmodule

// File: tb/tb_jtag_chain_arbiter.sv
// Bench for jtag_chain_arbiter: session-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_jtag_chain_arbiter;

    localparam int PARK    = 4;
    localparam int TIMEOUT = 16;
    localparam logic [5:0] PARK6 = 6'b001110;  // {tck,tdi,tms,nce,ncs,oe}

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] c_tck = 2'b00, c_tdi = 2'b10, c_tms = 2'b10;
    logic [1:0] c_nce = 2'b01, c_ncs = 2'b10, c_oe = 2'b11;
    logic       b_tdo = 1'b1, b_asdo = 1'b0;
    logic [1:0] gnt_o, preempt_o, c_tdo_o, c_asdo_o;
    logic       B_TCK, B_TDI, B_TMS, B_NCE, B_NCS, B_OE;
    logic [5:0] pins;

    assign pins = {B_TCK, B_TDI, B_TMS, B_NCE, B_NCS, B_OE};

    jtag_chain_arbiter #(
        .PARK_CYCLES    (PARK),
        .TIMEOUT_CYCLES (TIMEOUT),
        .TO_W           (16)
    ) dut (
        .CLK       (CLK),
        .RST_SYNC  (rst),
        .req_i     (req),
        .gnt_o     (gnt_o),
        .preempt_o (preempt_o),
        .c_tck_i   (c_tck),
        .c_tdi_i   (c_tdi),
        .c_tms_i   (c_tms),
        .c_nce_i   (c_nce),
        .c_ncs_i   (c_ncs),
        .c_oe_i    (c_oe),
        .c_tdo_o   (c_tdo_o),
        .c_asdo_o  (c_asdo_o),
        .B_TCK     (B_TCK),
        .B_TDI     (B_TDI),
        .B_TMS     (B_TMS),
        .B_NCE     (B_NCE),
        .B_NCS     (B_NCS),
        .B_OE      (B_OE),
        .B_TDO     (b_tdo),
        .B_ASDO    (b_asdo)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Session-level reference: who owns the pins, how long the pins have been parked,
    // how long the owner's TCK has sat still while the other client waits.
    int         m_owner = -1;
    bit         m_parking = 0;
    int         m_parked = 0;
    int         m_target = 0;
    int         m_rr = 0;
    int         m_idle = 0;
    bit [1:0]   m_lock = 0;
    bit         m_last_tck = 0;
    bit         m_valid = 0;
    logic [1:0] e_gnt = 0, e_pre = 0;
    logic [5:0] e_pins = PARK6;

    always @(posedge CLK) begin
        bit [1:0] el;
        bit       tck_now;
        int       other;
        el     = req & ~m_lock;
        e_pre  = 2'b00;
        e_pins = PARK6;
        if (rst) begin
            m_owner = -1; m_parking = 0; m_parked = 0; m_target = 0; m_rr = 0;
            m_idle = 0; m_lock = 0; m_last_tck = 0; e_gnt = 2'b00; m_valid = 1;
        end else begin
            tck_now = c_tck[(m_owner >= 0) ? m_owner : m_target];
            m_lock  = m_lock & req;
            if (m_owner >= 0) begin
                other = 1 - m_owner;
                if (!req[m_owner]) begin
                    m_rr = other;
                    m_target = el[other] ? other : m_owner;
                    m_owner = -1; m_parking = 1; m_parked = 0; e_gnt = 2'b00;
                end else begin
                    if (el[other] && tck_now == m_last_tck) m_idle++;
                    else m_idle = 0;
                    if (TIMEOUT > 0 && m_idle >= TIMEOUT) begin
                        e_pre[m_owner] = 1'b1;
                        m_lock[m_owner] = 1'b1;
                        m_target = other;
                        m_owner = -1; m_parking = 1; m_parked = 0; e_gnt = 2'b00;
                    end else begin
                        e_pins = {c_tck[m_owner], c_tdi[m_owner], c_tms[m_owner],
                                  c_nce[m_owner], c_ncs[m_owner], c_oe[m_owner]};
                    end
                end
            end else if (m_parking) begin
                m_parked++;
                if (m_parked == PARK) begin
                    m_parked = 0;
                    if (el[m_target]) begin
                        m_owner = m_target; m_parking = 0; m_idle = 0;
                        e_gnt = 2'(2'b01 << m_target);
                    end else if (el[1 - m_target]) begin
                        m_target = 1 - m_target;
                    end else begin
                        m_parking = 0;
                    end
                end
            end else if (el != 2'b00) begin
                m_parking = 1; m_parked = 0;
                m_target = (el == 2'b11) ? m_rr : (el[1] ? 1 : 0);
            end
            m_last_tck = tck_now;
        end
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            chk("cyc_gnt", gnt_o, e_gnt);
            chk("cyc_preempt", preempt_o, e_pre);
            chk("cyc_pins", pins, e_pins);
            chk("cyc_tdo", c_tdo_o, e_gnt & {2{b_tdo}});
            chk("cyc_asdo", c_asdo_o, e_gnt & {2{b_asdo}});
            chk("cyc_onehot", ($countones(gnt_o) <= 1), 1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        int npre;

        // T1: reset values, single request, grant latency, pin hand-over
        do_reset();
        chk("T1_rst_gnt", gnt_o, 2'b00);
        chk("T1_rst_pre", preempt_o, 2'b00);
        chk("T1_rst_pins", pins, 6'b001110);
        req = 2'b01;
        tick(4);
        chk("T1_gnt_early", gnt_o, 2'b00);
        chk("T1_model_early", e_gnt, 2'b00);
        tick(1);
        chk("T1_gnt", gnt_o, 2'b01);
        chk("T1_model_gnt", e_gnt, 2'b01);
        chk("T1_tms_park", B_TMS, 1'b1);
        chk("T1_tdo", c_tdo_o, 2'b01);
        tick(1);
        chk("T1_tms_client", B_TMS, 1'b0);
        chk("T1_pins_client0", pins, 6'b000101);

        // T2: simultaneous requests, client 0 first, then hand-over through park
        do_reset();
        c_tck = 2'b10;
        req = 2'b11;
        tick(5);
        chk("T2_gnt0", gnt_o, 2'b01);
        req = 2'b10;
        tick(1);
        chk("T2_release_gnt", gnt_o, 2'b00);
        chk("T2_park_tms", B_TMS, 1'b1);
        chk("T2_park_tck", B_TCK, 1'b0);
        tick(3);
        chk("T2_still_park", gnt_o, 2'b00);
        tick(1);
        chk("T2_gnt1", gnt_o, 2'b10);

        // T3: owner 1 freezes TCK high while client 0 waits -> preempt on 16th idle edge
        req = 2'b11;
        tick(15);
        chk("T3_no_pre_yet", preempt_o, 2'b00);
        chk("T3_gnt_held", gnt_o, 2'b10);
        chk("T3_tck_high", B_TCK, 1'b1);
        tick(1);
        chk("T3_preempt", preempt_o, 2'b10);
        chk("T3_gnt_drop", gnt_o, 2'b00);
        chk("T3_tck_forced", B_TCK, 1'b0);
        tick(1);
        chk("T3_pulse_end", preempt_o, 2'b00);
        tick(3);
        chk("T3_gnt0", gnt_o, 2'b01);

        // T4: preempted client 1 holds req -> ignored until it drops req once
        req = 2'b10;
        tick(20);
        chk("T4_lockout", gnt_o, 2'b00);
        req = 2'b00;
        tick(1);
        req = 2'b11;
        tick(4);
        chk("T4_wait", gnt_o, 2'b00);
        tick(1);
        chk("T4_rr_gnt1", gnt_o, 2'b10);

        // T5: reset during ownership with B_TCK high
        tick(2);
        chk("T5_tck_high", B_TCK, 1'b1);
        rst = 1'b1;
        tick(1);
        chk("T5_gnt", gnt_o, 2'b00);
        chk("T5_pins", pins, 6'b001110);
        chk("T5_pre", preempt_o, 2'b00);
        rst = 1'b0;

        // T6: owner toggles TCK every 8 cycles -> never preempted
        do_reset();
        c_tck = 2'b00;
        req = 2'b10;
        tick(5);
        chk("T6_gnt1", gnt_o, 2'b10);
        req = 2'b11;
        npre = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i % 8 == 0) c_tck[1] = ~c_tck[1];
            b_asdo = i[2];
            tick(1);
            if (preempt_o != 2'b00) npre++;
        end
        chk("T6_no_preempt", npre, 0);
        chk("T6_gnt_kept", gnt_o, 2'b10);

        // T7: owner release coincides with watchdog expiry -> plain release
        do_reset();
        c_tck = 2'b00;
        req = 2'b10;
        tick(5);
        chk("T7_gnt1", gnt_o, 2'b10);
        req = 2'b11;
        tick(15);
        chk("T7_no_pre_yet", preempt_o, 2'b00);
        req = 2'b01;
        tick(1);
        chk("T7_no_preempt", preempt_o, 2'b00);
        chk("T7_gnt_drop", gnt_o, 2'b00);
        tick(3);
        chk("T7_park", gnt_o, 2'b00);
        tick(1);
        chk("T7_gnt0", gnt_o, 2'b01);

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
